core_muldiv_seq: RTL
====================

CORE_MULDIV_SEQ -- requirements
Module: core_muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to work.
REQ-002 SHALL have parameter ITER, default 32, iterations per operation; ITER SHALL equal WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request pulse from EX stage; sampled only in IDLE.
REQ-006 SHALL have port op_div  input  1  1 = divide, 0 = multiply; sampled with start.
REQ-007 SHALL have port op_signed  input  1  1 = signed operands (ex_instr.s); sampled with start.
REQ-008 SHALL have port operand_a  input  32  multiplicand/dividend; sampled with start.
REQ-009 SHALL have port operand_b  input  32  multiplier/divisor; sampled with start.
REQ-010 SHALL have port flush  input  1  abort in-flight operation.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE; drives EX stall.
REQ-012 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-013 SHALL have port result  output  32  low 32 bits of product, or quotient.
REQ-014 SHALL have port zf  output  1  result == 0, valid with done, held with result.
REQ-015 SHALL have port div_zero  output  1  last divide had operand_b == 0, held with result.

Function
REQ-016 SHALL implement states IDLE, PREP, RUN, FIX, DONE.
REQ-017 SHALL move IDLE->PREP on start & ~flush and latch op_div, op_signed and operands at that edge (cycle 0).
REQ-018 SHALL in PREP replace each operand by its magnitude when op_signed and the operand is negative, and record result sign = sign_a ^ sign_b.
REQ-019 SHALL go PREP->DONE directly when op_div & operand_b == 0; otherwise PREP->RUN.
REQ-020 SHALL in RUN perform one shift-add (mul) or restoring shift-subtract (div) step per cycle, ITER cycles, counted by a 6-bit counter that wraps 31->0 only on the RUN->FIX transition.
REQ-021 SHALL in FIX two's-complement negate the magnitude when the recorded sign is 1; FIX->DONE unconditionally.
REQ-022 SHALL in DONE assert done for exactly one cycle, update result/zf/div_zero, then return to IDLE.
REQ-023 SHALL give normal latency: done high in cycle 35 after the start cycle; divide-by-zero: done high in cycle 2.
REQ-024 SHALL produce multiply result = low 32 bits of a*b, identical for signed and unsigned.
REQ-025 SHALL produce a divide quotient that truncates toward zero; no remainder output.
REQ-026 SHALL on divide-by-zero give result 32'hFFFF_FFFF, div_zero 1, zf 0, any signedness.
REQ-027 SHALL give 0x8000_0000 / 0xFFFF_FFFF signed = 0x8000_0000 with no special flag.
REQ-028 SHALL ignore start while busy; latched operands stay unchanged.
REQ-029 SHALL on flush in any non-IDLE state return to IDLE next cycle without a done pulse; result/zf/div_zero keep their previous values.
REQ-030 SHALL let flush win over a simultaneous start in IDLE, so no operation begins.
REQ-031 SHALL hold result, zf and div_zero stable from DONE until the next DONE.
REQ-032 SHALL allow a new start in the first IDLE cycle after DONE, so back-to-back ops run every 36 cycles.

Reset
REQ-033 SHALL on rst_n low at a clk edge force state IDLE, counter 0, busy 0, done 0, result 0, zf 1, div_zero 0.
REQ-034 SHALL let reset mid-operation abandon the operation with no done pulse; reset overrides flush and start.

Structure
REQ-035 SHALL place state enum muldiv_state_t and constant MULDIV_ITER (32) in shared package i2d_core_defines.
REQ-036 SHALL place the single-iteration datapath (shift-add / shift-subtract, 64-bit accumulator) in sub-module core_muldiv_step; all sequencing stays in core_muldiv_seq.

Verification
REQ-037 SHALL test unsigned mul 0x0001_0003 * 0x0000_0005 -> done at cycle 35, result 0x0005_000F, zf 0.
REQ-038 SHALL test signed div -7 / 2 -> result 0xFFFF_FFFD (-3); signed div 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000.
REQ-039 SHALL test div 5 / 0 -> done at cycle 2, result 0xFFFF_FFFF, div_zero 1; next mul 0 * 9 -> result 0, zf 1, div_zero 0.
REQ-040 SHALL test start at cycle 0, flush at cycle 10 -> busy low at cycle 11, no done, result unchanged; start+flush in IDLE -> busy stays 0.
REQ-041 SHALL test start pulsed during RUN with different operands -> ignored, original result delivered at cycle 35.
REQ-042 SHALL test rst_n low at cycle 20 -> next cycle busy 0, done 0, result 0, zf 1; no later done.

Source files
------------

// File: rtl/i2d_core_defines.sv
// Shared core definitions: sequencer state encoding and iteration count
// for the multi-cycle multiply/divide unit.
package i2d_core_defines;

  localparam int unsigned MULDIV_ITER = 32;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_PREP,
    MD_RUN,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/core_muldiv_step.sv
// One iteration of the mul/div datapath on a 2*WIDTH accumulator:
// shift-add for multiply, restoring shift-subtract for divide.
module core_muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               op_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  always_comb begin
    // multiply: acc = {partial, multiplier}; add on LSB then shift right
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // divide: acc = {remainder, dividend}; remainder shifted left can need WIDTH+1 bits
    rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
    rem_ge  = (rem_sh >= {1'b0, opnd_i});
    rem_sub = rem_sh[WIDTH-1:0] - opnd_i;
    if (op_div) begin
      if (rem_ge) begin
        acc_o = {rem_sub, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/core_muldiv_seq.sv
// Sequential multiply/divide unit: IDLE -> PREP -> RUN (ITER steps) -> FIX -> DONE.
// Operates on magnitudes and re-applies the sign in FIX.
module core_muldiv_seq
  import i2d_core_defines::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = MULDIV_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             div_zero
);

  muldiv_state_t      state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               op_div_q, op_div_d;
  logic               op_signed_q, op_signed_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zf_q, zf_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   mag_a, mag_b, step_opnd, fixed;
  logic [2*WIDTH-1:0] step_acc;

  assign step_opnd = op_div_q ? b_q : a_q;

  core_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op_div (op_div_q),
    .acc_i  (acc_q),
    .opnd_i (step_opnd),
    .acc_o  (step_acc)
  );

  always_comb begin
    mag_a = (op_signed_q && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
    mag_b = (op_signed_q && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
    fixed = sign_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];

    state_d     = state_q;
    cnt_d       = cnt_q;
    op_div_d    = op_div_q;
    op_signed_d = op_signed_q;
    sign_d      = sign_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    zf_d        = zf_q;
    div_zero_d  = div_zero_q;

    if (flush && (state_q != MD_IDLE)) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start && !flush) begin
            state_d     = MD_PREP;
            op_div_d    = op_div;
            op_signed_d = op_signed;
            a_d         = operand_a;
            b_d         = operand_b;
          end
        end
        MD_PREP: begin
          a_d    = mag_a;
          b_d    = mag_b;
          sign_d = op_signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          acc_d  = op_div_q ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          cnt_d  = '0;
          if (op_div_q && (b_q == '0)) begin
            state_d    = MD_DONE;
            result_d   = '1;
            zf_d       = 1'b0;
            div_zero_d = 1'b1;
          end else begin
            state_d = MD_RUN;
          end
        end
        MD_RUN: begin
          acc_d = step_acc;
          if (cnt_q == 6'(ITER - 1)) begin
            cnt_d   = '0;
            state_d = MD_FIX;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        MD_FIX: begin
          // outputs load on entry to DONE so they are valid alongside done
          state_d    = MD_DONE;
          result_d   = fixed;
          zf_d       = (fixed == '0);
          div_zero_d = 1'b0;
        end
        MD_DONE: begin
          state_d = MD_IDLE;
        end
        default: begin
          state_d = MD_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      op_div_q    <= 1'b0;
      op_signed_q <= 1'b0;
      sign_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      zf_q        <= 1'b1;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_div_q    <= op_div_d;
      op_signed_q <= op_signed_d;
      sign_q      <= sign_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      zf_q        <= zf_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy     = (state_q != MD_IDLE);
  assign done     = (state_q == MD_DONE);
  assign result   = result_q;
  assign zf       = zf_q;
  assign div_zero = div_zero_q;

endmodule
